vx_tex_req_arb: RTL
===================

// Module: vx_tex_req_arb
// PURPOSE
// - Upstream neighbour of the texture unit: merges texture requests from NUM_INPUTS
//   sources (cores/sockets) onto one texture-unit request channel, and routes texture
//   responses back to the issuing source.
// - Round-robin arbitration with per-source outstanding-request credit limit; source
//   index appended to the tag (LSBs) and stripped from the response.
// PARAMETERS
// - NUM_INPUTS   4    number of requesting sources (>=1; 1 = pass-through w/ register)
// - REQ_DATAW    128  opaque request payload (mask, coords, lod, stage), passed unchanged
// - RSP_DATAW    128  opaque response payload (texels), passed unchanged
// - TAG_WIDTH    16   source-side tag width
// - MAX_PENDING  8    max outstanding requests per source (>=1)
// - Derived: SEL_W = max(1,clog2(NUM_INPUTS)); OUT_TAGW = TAG_WIDTH+SEL_W; CNT_W = clog2(MAX_PENDING+1)
// PORTS
// - clk              in   1                    clock
// - reset            in   1                    synchronous, active-low reset
// - req_valid_in     in   NUM_INPUTS           per-source request valid
// - req_data_in      in   NUM_INPUTS*REQ_DATAW per-source payload
// - req_tag_in       in   NUM_INPUTS*TAG_WIDTH per-source tag
// - req_ready_in     out  NUM_INPUTS           per-source request ready
// - req_valid_out    out  1                    merged request valid to texture unit
// - req_data_out     out  REQ_DATAW            merged payload
// - req_tag_out      out  OUT_TAGW             {source tag, source index}
// - req_ready_out    in   1                    texture unit ready
// - rsp_valid_in     in   1                    response valid from texture unit
// - rsp_data_in      in   RSP_DATAW            response payload
// - rsp_tag_in       in   OUT_TAGW             returned tag; [SEL_W-1:0] = source index
// - rsp_ready_in     out  1                    response ready to texture unit
// - rsp_valid_out    out  NUM_INPUTS           per-source response valid (one-hot or zero)
// - rsp_data_out     out  RSP_DATAW            response payload (shared by all sources)
// - rsp_tag_out      out  TAG_WIDTH            source tag (index stripped)
// - rsp_ready_out    in   NUM_INPUTS           per-source response ready
// BEHAVIOUR
// - Reset (reset==0 at clk edge): req_valid_out=0, rsp_valid_out=0, rr_ptr=0, all pending
//   counters=0; data/tag outputs don't-care. Reset mid-transfer drops in-flight entries.
// - Eligible[i] = req_valid_in[i] && pend[i] < MAX_PENDING.
// - Grant: first eligible index at or after rr_ptr (wrapping NUM_INPUTS-1 -> 0).
//   req_ready_in[i] = grant[i] && output stage can accept; at most one bit set.
// - Request output stage: 2-entry skid buffer; 1-cycle latency in->out; full throughput
//   (1 req/cycle) while req_ready_out=1; req_ready_in deasserts only when both entries full.
//   Output data/tag held stable while req_valid_out && !req_ready_out.
// - On accepted input fire from source g: rr_ptr <= (g+1) mod NUM_INPUTS; pend[g]++.
//   rr_ptr unchanged on cycles with no fire.
// - Response stage: 1-entry register + bypass-free; rsp_ready_in = !rsp_full ||
//   rsp_ready_out[idx_of_held]. Held entry drives rsp_valid_out[idx]=1 only.
// - On response fire to source s: pend[s]--. Same-cycle inc & dec of same source -> unchanged.
// - rsp_tag_in index >= NUM_INPUTS: illegal; assertion fires in simulation.
// - pend never exceeds MAX_PENDING, never underflows (assertion on rsp for pend==0).
// - No reordering within a source; responses may return in any order across sources.
// CONFIGURATION
// - VX_TEX_ARB_PERF_EN defined: adds outputs perf_stall_cycles[NUM_INPUTS*PERF_CTR_BITS]
//   (per source: req_valid_in && !req_ready_in) and perf_credit_stalls (cycles any source
//   blocked solely by pend==MAX_PENDING); counters clear on reset, wrap on overflow.
// - Undefined: ports and counters absent; functional behaviour identical.
// TESTING
// - Reset, no stimulus -> req_valid_out=0, rsp_valid_out=0, req_ready_in=4'b0001.. gated only
//   by valid; first req from src2 tag=0x12 -> req_tag_out={0x12,2'd2} one cycle later.
// - All 4 sources valid every cycle, req_ready_out=1 -> grants order 0,1,2,3,0.. one per cycle.
// - MAX_PENDING=2, src1 sends 3 reqs, no responses -> 3rd held (req_ready_in[1]=0); one rsp
//   with index 1 delivered -> 3rd accepted next cycle.
// - req_ready_out=0 for 5 cycles with src0,src3 valid -> req_data_out/tag stable, 2 accepted
//   max, no loss/duplication after release.
// - rsp_tag_in={0xABCD,2'd3}, rsp_ready_out[3]=0 for 3 cycles -> rsp_valid_out=4'b1000 stable,
//   rsp_tag_out=0xABCD, rsp_ready_in=0 until drained.
// - Assert reset mid-stream with 2 reqs buffered -> next cycle all valids 0, pend=0, rr_ptr=0.

Source files
------------

// File: rtl/vx_tex_req_arb_if.sv
// Texture request/response bundle between the sources, the arbiter and the texture unit.
// Perf counter outputs exist only when VX_TEX_ARB_PERF_EN is defined.
interface vx_tex_req_arb_if #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned REQ_DATAW  = 128,
    parameter int unsigned RSP_DATAW  = 128,
    parameter int unsigned TAG_WIDTH  = 16
`ifdef VX_TEX_ARB_PERF_EN
    ,
    parameter int unsigned PERF_CTR_BITS = 32
`endif
);
    localparam int unsigned SEL_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned OUT_TAGW = TAG_WIDTH + SEL_W;

    logic [NUM_INPUTS-1:0]           req_valid_in;
    logic [NUM_INPUTS*REQ_DATAW-1:0] req_data_in;
    logic [NUM_INPUTS*TAG_WIDTH-1:0] req_tag_in;
    logic [NUM_INPUTS-1:0]           req_ready_in;
    logic                            req_valid_out;
    logic [REQ_DATAW-1:0]            req_data_out;
    logic [OUT_TAGW-1:0]             req_tag_out;
    logic                            req_ready_out;
    logic                            rsp_valid_in;
    logic [RSP_DATAW-1:0]            rsp_data_in;
    logic [OUT_TAGW-1:0]             rsp_tag_in;
    logic                            rsp_ready_in;
    logic [NUM_INPUTS-1:0]           rsp_valid_out;
    logic [RSP_DATAW-1:0]            rsp_data_out;
    logic [TAG_WIDTH-1:0]            rsp_tag_out;
    logic [NUM_INPUTS-1:0]           rsp_ready_out;
`ifdef VX_TEX_ARB_PERF_EN
    logic [NUM_INPUTS*PERF_CTR_BITS-1:0] perf_stall_cycles;
    logic [PERF_CTR_BITS-1:0]            perf_credit_stalls;
`endif

    modport slave (
        input  req_valid_in, req_data_in, req_tag_in, req_ready_out,
        input  rsp_valid_in, rsp_data_in, rsp_tag_in, rsp_ready_out,
        output req_ready_in, req_valid_out, req_data_out, req_tag_out,
        output rsp_ready_in, rsp_valid_out, rsp_data_out, rsp_tag_out
`ifdef VX_TEX_ARB_PERF_EN
        ,
        output perf_stall_cycles, perf_credit_stalls
`endif
    );

    modport master (
        output req_valid_in, req_data_in, req_tag_in, req_ready_out,
        output rsp_valid_in, rsp_data_in, rsp_tag_in, rsp_ready_out,
        input  req_ready_in, req_valid_out, req_data_out, req_tag_out,
        input  rsp_ready_in, rsp_valid_out, rsp_data_out, rsp_tag_out
`ifdef VX_TEX_ARB_PERF_EN
        ,
        input  perf_stall_cycles, perf_credit_stalls
`endif
    );
endinterface

// File: rtl/vx_tex_req_arb.sv
// Round-robin texture request arbiter with per-source credit limit and response routing.
// Optional perf counters enabled by defining VX_TEX_ARB_PERF_EN.
module vx_tex_req_arb #(
    parameter int unsigned NUM_INPUTS  = 4,
    parameter int unsigned REQ_DATAW   = 128,
    parameter int unsigned RSP_DATAW   = 128,
    parameter int unsigned TAG_WIDTH   = 16,
    parameter int unsigned MAX_PENDING = 8
`ifdef VX_TEX_ARB_PERF_EN
    ,
    parameter int unsigned PERF_CTR_BITS = 32
`endif
) (
    input logic             clk,
    input logic             reset,
    vx_tex_req_arb_if.slave bus
);
    localparam int unsigned SEL_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned OUT_TAGW = TAG_WIDTH + SEL_W;
    localparam int unsigned CNT_W    = $clog2(MAX_PENDING + 1);
    localparam int unsigned ENT_W    = OUT_TAGW + REQ_DATAW;

    logic [SEL_W-1:0]      rr_q, rr_d;
    logic [CNT_W-1:0]      pend_q [NUM_INPUTS];
    logic [CNT_W-1:0]      pend_d [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] eligible, grant;
    logic [SEL_W-1:0]      grant_idx;
    logic                  grant_vld;

    logic [ENT_W-1:0]      buf_q [2];
    logic [ENT_W-1:0]      push_ent;
    logic                  wr_q, rd_q;
    logic [1:0]            cnt_q, cnt_d;
    logic                  stage_ready, push, pop;

    logic                  rsp_full_q;
    logic [SEL_W-1:0]      rsp_idx_q, rsp_idx_in;
    logic [TAG_WIDTH-1:0]  rsp_tag_q;
    logic [RSP_DATAW-1:0]  rsp_data_q;
    logic                  rsp_fire_out, rsp_ready, rsp_load;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            eligible[i] = bus.req_valid_in[i] && (pend_q[i] < CNT_W'(MAX_PENDING));
        end
    end

    // First eligible source at or after rr_q, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= int'(NUM_INPUTS)) idx = idx - int'(NUM_INPUTS);
            if (!grant_vld && eligible[SEL_W'(idx)]) begin
                grant_idx = SEL_W'(idx);
                grant_vld = 1'b1;
            end
        end
        grant = '0;
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

    assign stage_ready = (cnt_q != 2'd2);
    assign push        = grant_vld && stage_ready;
    assign pop         = (cnt_q != 2'd0) && bus.req_ready_out;
    assign push_ent    = {bus.req_tag_in[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH], grant_idx,
                          bus.req_data_in[int'(grant_idx)*REQ_DATAW +: REQ_DATAW]};

    assign bus.req_ready_in  = stage_ready ? grant : '0;
    assign bus.req_valid_out = (cnt_q != 2'd0);
    assign bus.req_tag_out   = buf_q[rd_q][ENT_W-1:REQ_DATAW];
    assign bus.req_data_out  = buf_q[rd_q][REQ_DATAW-1:0];

    // Single response holding register; a new response may load as the held one drains.
    assign rsp_idx_in   = bus.rsp_tag_in[SEL_W-1:0];
    assign rsp_fire_out = rsp_full_q && bus.rsp_ready_out[rsp_idx_q];
    assign rsp_ready    = !rsp_full_q || rsp_fire_out;
    assign rsp_load     = bus.rsp_valid_in && rsp_ready;

    assign bus.rsp_ready_in = rsp_ready;
    assign bus.rsp_data_out = rsp_data_q;
    assign bus.rsp_tag_out  = rsp_tag_q;

    always_comb begin
        bus.rsp_valid_out = '0;
        if (rsp_full_q) bus.rsp_valid_out[rsp_idx_q] = 1'b1;
    end

    always_comb begin
        rr_d = rr_q;
        if (push) rr_d = (int'(grant_idx) == int'(NUM_INPUTS) - 1) ? '0 : grant_idx + SEL_W'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        for (int i = 0; i < NUM_INPUTS; i++) begin
            pend_d[i] = pend_q[i];
            if ((push && grant_idx == SEL_W'(i)) && !(rsp_fire_out && rsp_idx_q == SEL_W'(i))) begin
                pend_d[i] = pend_q[i] + CNT_W'(1);
            end else if (!(push && grant_idx == SEL_W'(i)) &&
                         (rsp_fire_out && rsp_idx_q == SEL_W'(i))) begin
                pend_d[i] = pend_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q       <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            rsp_full_q <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) pend_q[i] <= '0;
        end else begin
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_q ^ push;
            rd_q       <= rd_q ^ pop;
            rsp_full_q <= rsp_load || (rsp_full_q && !rsp_fire_out);
            for (int i = 0; i < NUM_INPUTS; i++) pend_q[i] <= pend_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_q] <= push_ent;
        if (rsp_load) begin
            rsp_idx_q  <= rsp_idx_in;
            rsp_tag_q  <= bus.rsp_tag_in[OUT_TAGW-1:SEL_W];
            rsp_data_q <= bus.rsp_data_in;
        end
    end

    rsp_idx_legal: assert property (@(posedge clk) disable iff (!reset)
        rsp_load |-> (32'(rsp_idx_in) < NUM_INPUTS));
    rsp_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        rsp_fire_out |-> (pend_q[rsp_idx_q] != '0));
    req_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        push |-> (pend_q[grant_idx] < CNT_W'(MAX_PENDING)));

`ifdef VX_TEX_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stall_q [NUM_INPUTS];
    logic [PERF_CTR_BITS-1:0] perf_credit_q;
    logic                     credit_blocked;

    always_comb begin
        credit_blocked = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            bus.perf_stall_cycles[i*PERF_CTR_BITS +: PERF_CTR_BITS] = perf_stall_q[i];
            if (bus.req_valid_in[i] && pend_q[i] == CNT_W'(MAX_PENDING)) credit_blocked = 1'b1;
        end
    end
    assign bus.perf_credit_stalls = perf_credit_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_credit_q <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) perf_stall_q[i] <= '0;
        end else begin
            if (credit_blocked) perf_credit_q <= perf_credit_q + PERF_CTR_BITS'(1);
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (bus.req_valid_in[i] && !bus.req_ready_in[i]) begin
                    perf_stall_q[i] <= perf_stall_q[i] + PERF_CTR_BITS'(1);
                end
            end
        end
    end
`endif
endmodule
